// File: rtl/sym_mod_pk.sv
// sym_mod_pk: packed-stream symbol mapper.
// Takes DW_IN-bit words from a Wishbone-style slave port. It repacks the bits
// LSB-first into 1/2/4/6-bit symbols and Gray-maps each symbol onto a W-bit
// I/Q constellation point. At end of frame it zero-pads the last partial
// symbol, and it holds its output under downstream backpressure.
module sym_mod_pk #(
    parameter int W     = 16,
    parameter int DW_IN = 8,
    parameter int CW    = 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [DW_IN-1:0]  DAT_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    output logic              ACK_O,
    input  logic [1:0]        MOD,
    output logic [2*W-1:0]    DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I,
    output logic [CW-1:0]     SYM_CNT
);

    localparam int ACC_W = DW_IN + 6;
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // round(a / sqrt(n)): smallest x with (2x+1)^2 * n > 4a^2, found by bisection
    function automatic longint round_div_sqrt(input longint a, input longint n);
        longint lo, hi, mid;
        lo = 0;
        hi = a;
        for (int unsigned i = 0; i < 64; i++) begin
            if (lo < hi) begin
                mid = (lo + hi) / 2;
                if ((2 * mid + 1) * (2 * mid + 1) * n > 4 * a * a) hi = mid;
                else lo = mid + 1;
            end
        end
        return lo;
    endfunction

    localparam longint A_R   = (longint'(1) << (W - 1)) - 1;
    localparam longint K2_R  = round_div_sqrt(A_R, 2);
    localparam longint K16_R = round_div_sqrt(A_R, 10);
    localparam longint K64_R = round_div_sqrt(A_R, 42);

    localparam logic [W-1:0] V_A    = W'(A_R);
    localparam logic [W-1:0] V_K2   = W'((K2_R > A_R) ? A_R : K2_R);
    localparam logic [W-1:0] L16_1  = W'((K16_R > A_R) ? A_R : K16_R);
    localparam logic [W-1:0] L16_3  = W'((3 * K16_R > A_R) ? A_R : 3 * K16_R);
    localparam logic [W-1:0] L64_1  = W'((K64_R > A_R) ? A_R : K64_R);
    localparam logic [W-1:0] L64_3  = W'((3 * K64_R > A_R) ? A_R : 3 * K64_R);
    localparam logic [W-1:0] L64_5  = W'((5 * K64_R > A_R) ? A_R : 5 * K64_R);
    localparam logic [W-1:0] L64_7  = W'((7 * K64_R > A_R) ? A_R : 7 * K64_R);

    localparam logic [CNT_W-1:0] PUSH_LIM = CNT_W'(ACC_W - DW_IN);
    localparam logic [CNT_W-1:0] DW_C     = CNT_W'(DW_IN);

    // 3-bit Gray: bit0 is the sign, bits[2:1] select the magnitude 1/3/5/7
    function automatic logic [W-1:0] gray3(input logic [2:0] b);
        logic [W-1:0] mag;
        case (b[2:1])
            2'b01:   mag = L64_1;
            2'b11:   mag = L64_3;
            2'b10:   mag = L64_5;
            default: mag = L64_7;
        endcase
        return b[0] ? mag : -mag;
    endfunction

    // 2-bit Gray: bit0 is the sign, bit1 selects the magnitude 1/3
    function automatic logic [W-1:0] gray2(input logic [1:0] b);
        logic [W-1:0] mag;
        mag = b[1] ? L16_1 : L16_3;
        return b[0] ? mag : -mag;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   dat_q, dat_d;
    logic             stb_q, stb_d;
    logic             cyc_q, cyc_d;
    logic [CW-1:0]    sym_cnt_q, sym_cnt_d;

    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] pop_amt;
    logic             free, pop, push;
    logic [W-1:0]     re_v, im_v;

    // Handshake decode: bits per symbol, input accept, output pop and its width
    always_comb begin
        case (mode_q)
            2'b11:   k = CNT_W'(6);
            2'b10:   k = CNT_W'(4);
            2'b00:   k = CNT_W'(2);
            default: k = CNT_W'(1);
        endcase
        free    = !stb_q || ACK_I;
        push    = CYC_I && STB_I && WE_I && (state_q == ST_RUN) && (cnt_q <= PUSH_LIM);
        pop     = free && ((cnt_q >= k) ||
                  ((state_q == ST_FLUSH) && (cnt_q != '0) && (cnt_q < k)));
        pop_amt = '0;
        if (pop) pop_amt = (cnt_q >= k) ? k : cnt_q;
    end

    // Symbol mapping from the low accumulator bits (bits at/above cnt are always zero)
    always_comb begin
        re_v = '0;
        im_v = '0;
        case (mode_q)
            2'b11: begin
                re_v = gray3(acc_q[2:0]);
                im_v = gray3(acc_q[5:3]);
            end
            2'b10: begin
                re_v = gray2(acc_q[1:0]);
                im_v = gray2(acc_q[3:2]);
            end
            2'b00: begin
                re_v = acc_q[0] ? V_K2 : -V_K2;
                im_v = acc_q[1] ? V_K2 : -V_K2;
            end
            default: begin
                re_v = acc_q[0] ? V_A : -V_A;
                im_v = '0;
            end
        endcase
    end

    // Next-state: accumulator push/pop, output register, symbol count, frame FSM
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cyc_d     = cyc_q;
        sym_cnt_d = sym_cnt_q;
        dat_d     = dat_q;
        stb_d     = stb_q;

        if (stb_q && ACK_I) sym_cnt_d = sym_cnt_q + CW'(1);

        if (pop) begin
            dat_d = {im_v, re_v};
            stb_d = 1'b1;
        end else if (free) begin
            stb_d = 1'b0;
        end

        // New word lands right above the bits that survive this cycle's pop
        acc_d = (acc_q >> pop_amt) |
                (push ? (ACC_W'(DAT_I) << (cnt_q - pop_amt)) : '0);
        cnt_d = cnt_q - pop_amt + (push ? DW_C : '0);

        case (state_q)
            ST_IDLE: begin
                if (CYC_I) begin
                    mode_d    = MOD;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sym_cnt_d = '0;
                    cyc_d     = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!CYC_I) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if ((cnt_q == '0) && free) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers, asynchronous active-high reset
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            mode_q    <= 2'b00;
            acc_q     <= '0;
            cnt_q     <= '0;
            dat_q     <= '0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
            sym_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            cyc_q     <= cyc_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    assign ACK_O   = push;
    assign DAT_O   = dat_q;
    assign STB_O   = stb_q;
    assign WE_O    = stb_q;
    assign CYC_O   = cyc_q;
    assign SYM_CNT = sym_cnt_q;

endmodule
